wf_i2s_rx: RTL and testbench

I2S receiver (slave) that recovers frames from an external codec ADC. It oversamples the asynchronous SCLK, LRCK and SDATA lines in the core clock domain and deserializes MSB-first two's-complement samples. It presents each completed left/right pair as a single-cycle-valid parallel word. It is the capture-side counterpart of the I2S timing/pulse generator and sits between the codec pins and the audio datapath.

---
 rtl/wf_i2s_rx.sv | 156 +++++++++++++++
 tb/tb_wf_i2s_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wf_i2s_rx.sv
// I2S slave receiver: oversamples SCLK/LRCK/SDATA in the clk domain and deserializes
// MSB-first samples, presenting each left/right pair as one single-cycle-valid word.
module wf_i2s_rx #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i2s_sclk,
  input  logic                    i2s_lrck,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] left_data,
  output logic [SAMPLE_WIDTH-1:0] right_data,
  output logic                    sample_valid,
  output logic                    short_slot,
  output logic                    locked
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    RX_LEFT,
    RX_RIGHT
  } state_t;

  // Synchronizers: sclk gets a third stage so its rising edge lines up with lrck/sdata s2.
  logic sclk_s1, sclk_s2, sclk_s3;
  logic lrck_s1, lrck_s2;
  logic sdata_s1, sdata_s2;

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      lrck_s1  <= 1'b0;
      lrck_s2  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sclk_s1  <= i2s_sclk;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      lrck_s1  <= i2s_lrck;
      lrck_s2  <= lrck_s1;
      sdata_s1 <= i2s_sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  logic sclk_rise;
  assign sclk_rise = sclk_s2 & ~sclk_s3;

  state_t                  state, state_nxt;
  logic                    ws_d, ws_dd;
  logic [SAMPLE_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]           bit_cnt, bit_cnt_nxt;
  logic [SAMPLE_WIDTH-1:0] left_pend, left_pend_nxt;
  logic [SAMPLE_WIDTH-1:0] left_data_nxt, right_data_nxt;
  logic                    sample_valid_nxt, short_slot_nxt, locked_nxt;

  // The bit captured at this rise belongs to the channel latched at the previous rise,
  // so a change between the two previous LRCK samples marks this bit as a slot MSB.
  logic                    slot_start;
  logic [SAMPLE_WIDTH-1:0] commit_word;
  logic                    commit_short;
  logic [SAMPLE_WIDTH-1:0] shift_word;
  logic [SAMPLE_WIDTH-1:0] first_word;

  assign slot_start   = ws_d ^ ws_dd;
  assign commit_word  = shreg << (FULL - bit_cnt);
  assign commit_short = (bit_cnt < FULL);
  assign shift_word   = (shreg << 1) | SAMPLE_WIDTH'(sdata_s2);
  assign first_word   = SAMPLE_WIDTH'(sdata_s2);

  // NOTE: every signal written here gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt        = state;
    shreg_nxt        = shreg;
    bit_cnt_nxt      = bit_cnt;
    left_pend_nxt    = left_pend;
    left_data_nxt    = left_data;
    right_data_nxt   = right_data;
    sample_valid_nxt = 1'b0;
    short_slot_nxt   = 1'b0;
    locked_nxt       = locked;

    if (sclk_rise) begin
      unique case (state)
        WAIT_SYNC: begin
          if (slot_start && !ws_d) begin
            shreg_nxt   = first_word;
            bit_cnt_nxt = CW'(1);
            locked_nxt  = 1'b1;
            state_nxt   = RX_LEFT;
          end
        end
        RX_LEFT, RX_RIGHT: begin
          if (slot_start) begin
            short_slot_nxt = commit_short;
            shreg_nxt      = first_word;
            bit_cnt_nxt    = CW'(1);
            if (state == RX_LEFT) begin
              left_pend_nxt = commit_word;
              state_nxt     = RX_RIGHT;
            end else begin
              left_data_nxt    = left_pend;
              right_data_nxt   = commit_word;
              sample_valid_nxt = 1'b1;
              state_nxt        = RX_LEFT;
            end
          end else if (bit_cnt < FULL) begin
            shreg_nxt   = shift_word;
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
        default: state_nxt = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_SYNC;
      ws_d         <= 1'b0;
      ws_dd        <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      left_pend    <= '0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      short_slot   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      if (sclk_rise) begin
        ws_d  <= lrck_s2;
        ws_dd <= ws_d;
      end
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_cnt      <= bit_cnt_nxt;
      left_pend    <= left_pend_nxt;
      left_data    <= left_data_nxt;
      right_data   <= right_data_nxt;
      sample_valid <= sample_valid_nxt;
      short_slot   <= short_slot_nxt;
      locked       <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_wf_i2s_rx.sv
// Directed bench for wf_i2s_rx: drives an I2S stream (data lagging LRCK by one SCLK)
// and checks committed pairs, short-slot pulses, locking, reset and latency.
module tb_wf_i2s_rx;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sclk, lrck, sdata;
  logic [SW-1:0] left_data, right_data;
  logic          sample_valid, short_slot, locked;

  wf_i2s_rx #(.SAMPLE_WIDTH(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_sclk     (sclk),
    .i2s_lrck     (lrck),
    .i2s_sdata    (sdata),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .short_slot   (short_slot),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            mark = 0;
  int            pulse_cnt = 0;
  int            short_cnt = 0;
  int            last_lat = -1;
  logic [SW-1:0] cap_l = '0;
  logic [SW-1:0] cap_r = '0;
  logic          prev_bit = 1'b0;
  logic          prev_lmsb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // mark holds the index of the clk edge that first samples the SCLK rise carrying a
  // left MSB; a pulse seen after edge mark+2 gives last_lat == 2.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      cap_l     <= left_data;
      cap_r     <= right_data;
      last_lat  <= cyc - mark;
    end
    if (short_slot === 1'b1) short_cnt <= short_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCLK period: SDATA carries the previous logical bit, as I2S lags data by one SCLK.
  task automatic period(input logic ws, input logic b, input int half, input logic is_lmsb);
    logic mark_now;
    sclk      = 1'b0;
    lrck      = ws;
    sdata     = prev_bit;
    prev_bit  = b;
    mark_now  = prev_lmsb;
    prev_lmsb = is_lmsb;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    if (mark_now) mark = cyc + 1;
    repeat (half) @(negedge clk);
  endtask

  task automatic drive_bits(input logic ws, input logic [31:0] word, input int nbits,
                            input int first, input int last, input int half);
    for (int i = first; i <= last; i++)
      period(ws, (i < nbits) ? word[nbits-1-i] : 1'b0, half, (!ws && i == 0));
  endtask

  task automatic drive_slot(input logic ws, input logic [31:0] word, input int nbits,
                            input int slot_len, input int half);
    drive_bits(ws, word, nbits, 0, slot_len - 1, half);
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_left"}, 32'(left_data), 32'h0);
    check({tag, "_right"}, 32'(right_data), 32'h0);
    check({tag, "_valid"}, 32'(sample_valid), 32'h0);
    check({tag, "_short"}, 32'(short_slot), 32'h0);
    check({tag, "_locked"}, 32'(locked), 32'h0);
  endtask

  initial begin
    int p0;
    int s0;
    reset = 1'b1;
    sclk  = 1'b0;
    lrck  = 1'b0;
    sdata = 1'b0;
    repeat (4) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clk);

    // 32-bit slots, SCLK = clk/16: priming right slot, then 0xA5C3 / 0x1234.
    p0 = pulse_cnt;
    s0 = short_cnt;
    drive_slot(1'b1, 32'h0, 16, 32, 8);
    check("prime_unlocked", 32'(locked), 32'h0);
    drive_slot(1'b0, 32'hA5C3, 16, 32, 8);
    check("locked_at_left", 32'(locked), 32'h1);
    drive_slot(1'b1, 32'h1234, 16, 32, 8);
    check("no_pulse_before_commit", 32'(pulse_cnt - p0), 32'h0);
    drive_slot(1'b0, 32'h8000, 16, 32, 8);
    check("pair1_count", 32'(pulse_cnt - p0), 32'h1);
    check("pair1_left", 32'(cap_l), 32'hA5C3);
    check("pair1_right", 32'(cap_r), 32'h1234);
    check("pair1_no_short", 32'(short_cnt - s0), 32'h0);
    check("latency_slow", 32'(last_lat), 32'h2);
    drive_slot(1'b1, 32'h7FFF, 16, 32, 8);

    // 8-bit slots: sign-check pair commits first, then 0xAB / 0xCD left-justified.
    s0 = short_cnt;
    drive_slot(1'b0, 32'hAB, 8, 8, 8);
    check("sign_left", 32'(cap_l), 32'h8000);
    check("sign_right", 32'(cap_r), 32'h7FFF);
    drive_slot(1'b1, 32'hCD, 8, 8, 8);
    drive_slot(1'b0, 32'hAB, 8, 8, 8);
    check("short_left", 32'(cap_l), 32'hAB00);
    check("short_right", 32'(cap_r), 32'hCD00);
    check("short_pulses", 32'(short_cnt - s0), 32'h2);

    // One-clk reset in the middle of a left slot.
    drive_slot(1'b1, 32'h1111, 16, 16, 4);
    drive_bits(1'b0, 32'h2222, 16, 0, 4, 4);
    pulse_reset(1);
    check_cleared("midleft_reset");
    p0 = pulse_cnt;
    drive_bits(1'b0, 32'h2222, 16, 5, 15, 4);
    drive_slot(1'b1, 32'h3333, 16, 16, 4);
    check("midleft_unlocked", 32'(locked), 32'h0);
    drive_slot(1'b0, 32'h4444, 16, 16, 4);
    check("midleft_relock", 32'(locked), 32'h1);
    check("midleft_no_pulse", 32'(pulse_cnt - p0), 32'h0);
    drive_slot(1'b1, 32'h5555, 16, 16, 4);
    drive_slot(1'b0, 32'h6666, 16, 16, 4);
    check("midleft_count", 32'(pulse_cnt - p0), 32'h1);
    check("midleft_left", 32'(cap_l), 32'h4444);
    check("midleft_right", 32'(cap_r), 32'h5555);

    // Reset released in the middle of a right slot with LRCK high.
    drive_bits(1'b1, 32'h7777, 16, 0, 5, 4);
    pulse_reset(3);
    p0 = pulse_cnt;
    drive_bits(1'b1, 32'h7777, 16, 6, 15, 4);
    check("midright_unlocked", 32'(locked), 32'h0);
    drive_slot(1'b0, 32'h8001, 16, 16, 4);
    check("midright_lock", 32'(locked), 32'h1);
    check("midright_no_pulse", 32'(pulse_cnt - p0), 32'h0);
    drive_slot(1'b1, 32'h7FFE, 16, 16, 4);
    drive_slot(1'b0, 32'h0F0F, 16, 16, 4);
    check("midright_count", 32'(pulse_cnt - p0), 32'h1);
    check("midright_left", 32'(cap_l), 32'h8001);
    check("midright_right", 32'(cap_r), 32'h7FFE);

    // 100 continuous frames at SCLK = clk/4 after a fresh reset.
    pulse_reset(2);
    drive_slot(1'b1, 32'h0, 16, 16, 2);
    p0 = pulse_cnt;
    for (int i = 0; i < 100; i++) begin
      drive_slot(1'b0, 32'h0100 + 32'(i), 16, 16, 2);
      if (i > 0) begin
        check("stream_left", 32'(cap_l), 32'h0100 + 32'(i - 1));
        check("stream_right", 32'(cap_r), 32'h8000 + 32'(i - 1));
      end
      drive_slot(1'b1, 32'h8000 + 32'(i), 16, 16, 2);
    end
    drive_slot(1'b0, 32'h0, 16, 16, 2);
    check("stream_last_left", 32'(cap_l), 32'h0163);
    check("stream_last_right", 32'(cap_r), 32'h8063);
    check("stream_count", 32'(pulse_cnt - p0), 32'd100);
    check("latency_fast", 32'(last_lat), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of stimulus, required finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
